coord_collector_mc: RTL and testbench
=====================================

Name: coord_collector_mc

Overview:
- Parametrised multi-channel coordinate collector for the pathfinding accelerator.
- Captures an NUM_CH-wide coordinate tuple (x, y, ...) on each accepted "enter" request and writes it to NUM_CH parallel single-port coordinate memories at a shared address.
- Tracks the stored point count, flags full/overflow, and terminates collection on "finish".
- Sits between the board button/switch inputs and the per-axis pathfinding memories; feeds the HEX display path via last_coord and count.

Parameters:
- COORD_W, 8, bits per coordinate channel.
- NUM_CH, 2, number of coordinate channels (axes); one memory write-enable per channel.
- DEPTH, 256, maximum stored points; equals the memory depth.
- ADDR_W, $clog2(DEPTH), memory address width.
- DEBOUNCE_CYC, 16, stable cycles required when COORD_DEBOUNCE_EN is defined; ignored otherwise.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- coord_in, input, NUM_CH*COORD_W, channel c at bits [c*COORD_W +: COORD_W].
- enter_req, input, 1, active-high level request (e.g. inverted KEY); asynchronous to clk.
- finish_req, input, 1, active-high level request; asynchronous to clk.
- restart, input, 1, synchronous pulse; leaves DONE and clears the stored count.
- mem_addr, output, ADDR_W, write address shared by all channels.
- mem_data, output, NUM_CH*COORD_W, write data; same channel packing as coord_in.
- mem_wren, output, NUM_CH, per-channel write enable; all bits move together.
- count, output, ADDR_W+1, number of points stored (0..DEPTH).
- last_coord, output, NUM_CH*COORD_W, most recently written tuple, for display.
- full, output, 1, count == DEPTH.
- overflow, output, 1, sticky; enter accepted while full.
- done, output, 1, high in the DONE state.

Behaviour:
- Reset values: all outputs 0; state COLLECT; synchroniser and edge flops 0.
- Input conditioning:
  - enter_req and finish_req each pass through a 2-flop synchroniser.
  - A rising-edge detector follows each synchroniser; an "event" is one clk pulse per rising edge.
  - Holding a request high produces exactly one event.
- States:
  - COLLECT: enter event and !full, go to WRITE.
    - coord_in is latched into mem_data and mem_addr = count[ADDR_W-1:0] on that edge.
    - enter event and full: overflow <= 1, no write, stay in COLLECT.
    - finish event alone: go to DONE.
  - WRITE, one cycle:
    - mem_wren = all ones.
    - count increments and last_coord <= mem_data at the cycle-end edge.
    - Next state: DONE if a finish event arrived in the COLLECT-exit cycle or during WRITE; otherwise COLLECT.
  - DONE:
    - done = 1.
    - enter and finish events are ignored; overflow is held.
    - restart: count <= 0, overflow <= 0, done <= 0, go to COLLECT. last_coord is held.
- Restart is ignored outside DONE.
- Latency: mem_wren is high for exactly one cycle, starting on the 4th rising clk edge after enter_req is first sampled high (without debounce).
- mem_wren is 0 in every cycle except WRITE. mem_addr and mem_data are held between writes.
- Simultaneous enter and finish events: the write completes first, then the block enters DONE. The point is stored.
- Full boundary:
  - The write at address DEPTH-1 sets count = DEPTH and full = 1.
  - The address never wraps.
- Reset asserted during WRITE: mem_wren is forced to 0 in that cycle and the write is suppressed; all state clears.
- Events arriving during WRITE other than finish are dropped.
- count and full are valid combinationally from registered state (no extra latency).

Optional Feature:
- Macro: COORD_DEBOUNCE_EN.
- Defined:
  - After synchronisation, each request goes through a counter-based debouncer.
  - The debounced level changes only after the synchronised input has differed from it for DEBOUNCE_CYC consecutive cycles.
  - The edge detector uses the debounced level.
  - enter-to-mem_wren latency grows by DEBOUNCE_CYC cycles.
  - Glitches shorter than DEBOUNCE_CYC produce no event.
- Not defined: no debouncer logic is instantiated; latency is as stated above.

Test Plan:
- Reset, then coord_in = {0x05, 0x0A} and enter_req held high for 10 cycles -> exactly one mem_wren = 2'b11 pulse on edge 4, mem_addr = 0, mem_data = 0x050A, count = 1, last_coord = 0x050A.
- Three enters with tuples 0x0102, 0x0304, 0x0506 -> writes at addresses 0, 1, 2 with matching data; count = 3; full = 0.
- DEPTH = 4: five enters -> four writes at addresses 0..3, full = 1 after the 4th, 5th enter gives no mem_wren, overflow = 1, count = 4.
- enter_req and finish_req rising on the same cycle -> one write at address count, then done = 1. A later enter produces no write. restart -> done = 0, count = 0, overflow = 0, next enter writes at address 0.
- reset asserted in the WRITE cycle -> mem_wren = 0 that cycle, count = 0, done = 0.
- With COORD_DEBOUNCE_EN and DEBOUNCE_CYC = 16:
  - a 10-cycle enter_req glitch -> no write;
  - a 40-cycle press -> one write, DEBOUNCE_CYC cycles later than without the macro.

Source files
------------

// File: rtl/coord_collector_mc_if.sv
// -----------------------------------------------------------------------------
// coord_collector_mc_if
// Groups the request inputs and memory/display outputs of coord_collector_mc.
//   slave  modport : collector side (requests in, memory/status out)
//   master modport : driver side (requests out, memory/status in)
// Signals:
//   coord_in   - NUM_CH packed coordinates, channel c at [c*COORD_W +: COORD_W]
//   enter_req  - asynchronous level request to store coord_in
//   finish_req - asynchronous level request to end collection
//   restart    - synchronous pulse, leaves DONE and clears the count
//   mem_addr   - shared write address
//   mem_data   - write data, same packing as coord_in
//   mem_wren   - per-channel write enable (all bits move together)
//   count      - number of stored points (0..DEPTH)
//   last_coord - most recently written tuple
//   full       - count == DEPTH
//   overflow   - sticky, enter accepted while full
//   done       - collection finished
// -----------------------------------------------------------------------------
interface coord_collector_mc_if #(
  parameter int COORD_W = 8,
  parameter int NUM_CH  = 2,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = $clog2(DEPTH)
);
  logic [NUM_CH*COORD_W-1:0] coord_in;
  logic                      enter_req;
  logic                      finish_req;
  logic                      restart;
  logic [ADDR_W-1:0]         mem_addr;
  logic [NUM_CH*COORD_W-1:0] mem_data;
  logic [NUM_CH-1:0]         mem_wren;
  logic [ADDR_W:0]           count;
  logic [NUM_CH*COORD_W-1:0] last_coord;
  logic                      full;
  logic                      overflow;
  logic                      done;

  modport slave (
    input  coord_in, enter_req, finish_req, restart,
    output mem_addr, mem_data, mem_wren, count, last_coord, full, overflow, done
  );

  modport master (
    output coord_in, enter_req, finish_req, restart,
    input  mem_addr, mem_data, mem_wren, count, last_coord, full, overflow, done
  );
endinterface

// File: rtl/coord_collector_mc.sv
// -----------------------------------------------------------------------------
// coord_collector_mc
// Multi-channel coordinate collector. Each enter event stores the NUM_CH-wide
// coord_in tuple into NUM_CH parallel memories at a shared address; a finish
// event ends collection (DONE) until restart.
// Ports:
//   clk   - system clock
//   reset - synchronous active-high reset
//   bus   - coord_collector_mc_if.slave (requests in, memory/status out)
// Optional feature macro: COORD_DEBOUNCE_EN
//   When defined, each synchronised request is filtered by a counter-based
//   debouncer (DEBOUNCE_CYC stable cycles) before edge detection.
// -----------------------------------------------------------------------------
module coord_collector_mc #(
  parameter int COORD_W      = 8,
  parameter int NUM_CH       = 2,
  parameter int DEPTH        = 256,
  parameter int ADDR_W       = $clog2(DEPTH),
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  coord_collector_mc_if.slave  bus
);
  localparam int              DW      = NUM_CH * COORD_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_WRITE   = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  // bit 0 = enter request, bit 1 = finish request
  logic [1:0]        meta_q, sync_q, prev_q;
  logic [1:0]        lvl_s, ev_s;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic [DW-1:0]     last_q, last_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  // finish seen while a write is in flight; honoured once the write completes
  logic              fin_pend_q, fin_pend_d;
  logic              full_s, wr_s;

`ifdef COORD_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
  logic [CNT_W-1:0] db_cnt_q [2];
  logic [1:0]       db_lvl_q;

  // Debouncer: level follows sync only after DEBOUNCE_CYC consecutive differing cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      db_lvl_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        db_cnt_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_q[i] != db_lvl_q[i]) begin
          if (db_cnt_q[i] == CNT_LAST) begin
            db_lvl_q[i] <= sync_q[i];
            db_cnt_q[i] <= {CNT_W{1'b0}};
          end else begin
            db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
          end
        end else begin
          db_cnt_q[i] <= {CNT_W{1'b0}};
        end
      end
    end
  end

  assign lvl_s = db_lvl_q;
`else
  assign lvl_s = sync_q;
`endif

  // One pulse per rising edge of the conditioned request level
  assign ev_s   = lvl_s & ~prev_q;
  assign full_s = (count_q == DEPTH_C);

  // Next-state and write-enable decode
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    last_d     = last_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    fin_pend_d = fin_pend_q;
    wr_s       = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        if (ev_s[0] && !full_s) begin
          state_d    = ST_WRITE;
          addr_d     = count_q[ADDR_W-1:0];
          data_d     = bus.coord_in;
          fin_pend_d = ev_s[1];
        end else begin
          fin_pend_d = 1'b0;
          if (ev_s[0]) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
          if (ev_s[1]) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_COLLECT;
          end
        end
      end
      ST_WRITE: begin
        wr_s       = 1'b1;
        count_d    = count_q + {{ADDR_W{1'b0}}, 1'b1};
        last_d     = data_q;
        fin_pend_d = 1'b0;
        if (fin_pend_q || ev_s[1]) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_DONE: begin
        if (bus.restart) begin
          state_d = ST_COLLECT;
          count_d = {(ADDR_W + 1){1'b0}};
          ovf_d   = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  // State, synchroniser and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_COLLECT;
      meta_q     <= 2'b00;
      sync_q     <= 2'b00;
      prev_q     <= 2'b00;
      addr_q     <= {ADDR_W{1'b0}};
      data_q     <= {DW{1'b0}};
      last_q     <= {DW{1'b0}};
      count_q    <= {(ADDR_W + 1){1'b0}};
      ovf_q      <= 1'b0;
      fin_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      meta_q     <= {bus.finish_req, bus.enter_req};
      sync_q     <= meta_q;
      prev_q     <= lvl_s;
      addr_q     <= addr_d;
      data_q     <= data_d;
      last_q     <= last_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      fin_pend_q <= fin_pend_d;
    end
  end

  // reset gates the enable so a write cycle hit by reset never reaches memory
  assign bus.mem_wren   = {NUM_CH{wr_s & ~reset}};
  assign bus.mem_addr   = addr_q;
  assign bus.mem_data   = data_q;
  assign bus.count      = count_q;
  assign bus.last_coord = last_q;
  assign bus.full       = full_s;
  assign bus.overflow   = ovf_q;
  assign bus.done       = (state_q == ST_DONE);
endmodule

// File: tb/tb_coord_collector_mc.sv
// Self-checking bench for coord_collector_mc (DEPTH = 4 so the full boundary
// is reachable). A transaction-level model predicts every output each cycle.
module tb_coord_collector_mc;
  localparam int COORD_W      = 8;
  localparam int NUM_CH       = 2;
  localparam int DEPTH        = 4;
  localparam int ADDR_W       = $clog2(DEPTH);
  localparam int DEBOUNCE_CYC = 16;
  localparam int DW           = NUM_CH * COORD_W;
`ifdef COORD_DEBOUNCE_EN
  localparam int HOLD = 40;
  localparam int LAT  = 3 + DEBOUNCE_CYC;
`else
  localparam int HOLD = 10;
  localparam int LAT  = 3;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   ecnt  = 0;
  bit   chk_en = 1'b0;

  coord_collector_mc_if #(.COORD_W(COORD_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();

  coord_collector_mc #(
    .COORD_W(COORD_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // h[i][j] = request i as sampled j+1 edges ago (0 enter, 1 finish)
  bit                h [2][3];
  int                m_count = 0;
  bit                m_ovf = 1'b0, m_done = 1'b0, m_wr = 1'b0, m_wr_fin = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DW-1:0]     m_data = '0, m_last = '0;
`ifdef COORD_DEBOUNCE_EN
  bit db_cur [2];
  bit db_prev [2];
  int db_run [2];
`endif

  // log of writes the DUT actually issued
  int            wlog_addr [$];
  logic [DW-1:0] wlog_data [$];
  int            wr_edge = 0;
  int            first_edge = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, ecnt);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic model_step();
    bit ev [2];
    bit smp [2];
    smp[0] = bus.enter_req;
    smp[1] = bus.finish_req;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 3; j++) h[i][j] = 1'b0;
`ifdef COORD_DEBOUNCE_EN
        db_cur[i] = 1'b0; db_prev[i] = 1'b0; db_run[i] = 0;
`endif
      end
      m_count = 0; m_ovf = 1'b0; m_done = 1'b0; m_wr = 1'b0; m_wr_fin = 1'b0;
      m_addr = '0; m_data = '0; m_last = '0;
      return;
    end
    for (int i = 0; i < 2; i++) begin
`ifdef COORD_DEBOUNCE_EN
      ev[i] = db_cur[i] & ~db_prev[i];
      db_prev[i] = db_cur[i];
      if (h[i][1] != db_cur[i]) begin
        db_run[i]++;
        if (db_run[i] == DEBOUNCE_CYC) begin db_cur[i] = h[i][1]; db_run[i] = 0; end
      end else begin
        db_run[i] = 0;
      end
`else
      // request seen two edges after sampling, rising against the sample before it
      ev[i] = h[i][1] & ~h[i][2];
`endif
      h[i][2] = h[i][1]; h[i][1] = h[i][0]; h[i][0] = smp[i];
    end
    if (m_wr) begin
      m_count++; m_last = m_data; m_wr = 1'b0;
      m_done = m_wr_fin | ev[1];
    end else if (m_done) begin
      if (bus.restart) begin m_done = 1'b0; m_count = 0; m_ovf = 1'b0; end
    end else if (ev[0] && m_count < DEPTH) begin
      m_wr = 1'b1; m_addr = ADDR_W'(m_count); m_data = bus.coord_in; m_wr_fin = ev[1];
    end else begin
      if (ev[0]) m_ovf = 1'b1;
      if (ev[1]) m_done = 1'b1;
    end
  endtask

  // Compare every output against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      cmp("mem_wren", 64'(bus.mem_wren), 64'((m_wr && !reset) ? {NUM_CH{1'b1}} : {NUM_CH{1'b0}}));
      cmp("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
      cmp("mem_data", 64'(bus.mem_data), 64'(m_data));
      cmp("count", 64'(bus.count), 64'(m_count));
      cmp("last_coord", 64'(bus.last_coord), 64'(m_last));
      cmp("full", 64'(bus.full), 64'(m_count == DEPTH));
      cmp("overflow", 64'(bus.overflow), 64'(m_ovf));
      cmp("done", 64'(bus.done), 64'(m_done));
    end
    if (bus.mem_wren != '0) begin
      wlog_addr.push_back(int'(bus.mem_addr));
      wlog_data.push_back(bus.mem_data);
      wr_edge = ecnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    ecnt++;
    model_step();
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.enter_req = 1'b0; bus.finish_req = 1'b0; bus.restart = 1'b0;
    tick(); tick();
    reset = 1'b0;
    wlog_addr.delete(); wlog_data.delete();
  endtask

  task automatic press(input logic [DW-1:0] c, input bit fin);
    bus.coord_in = c; bus.enter_req = 1'b1; bus.finish_req = fin;
    first_edge = ecnt + 1;
    repeat (HOLD) tick();
    bus.enter_req = 1'b0; bus.finish_req = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    bus.coord_in = '0; bus.enter_req = 1'b0; bus.finish_req = 1'b0; bus.restart = 1'b0;
    do_reset();
    chk_en = 1'b1;
    tick();
    cmp("reset_count", 64'(bus.count), 64'd0);
    cmp("reset_done", 64'(bus.done), 64'd0);

    // 1: single held press stores one point with fixed latency
    press(16'h050A, 1'b0);
    cmp("t1_nwrites", 64'(wlog_addr.size()), 64'd1);
    if (wlog_addr.size() > 0) begin
      cmp("t1_addr", 64'(wlog_addr[0]), 64'd0);
      cmp("t1_data", 64'(wlog_data[0]), 64'h050A);
    end
    cmp("t1_latency", 64'(wr_edge - first_edge), 64'(LAT));
    cmp("t1_count", 64'(bus.count), 64'd1);
    cmp("t1_last", 64'(bus.last_coord), 64'h050A);

    // 2: three sequential points
    do_reset();
    press(16'h0102, 1'b0); press(16'h0304, 1'b0); press(16'h0506, 1'b0);
    cmp("t2_nwrites", 64'(wlog_addr.size()), 64'd3);
    for (int i = 0; i < wlog_addr.size() && i < 3; i++) begin
      cmp("t2_addr", 64'(wlog_addr[i]), 64'(i));
      cmp("t2_data", 64'(wlog_data[i]), 64'(16'h0102 + 16'(i) * 16'h0202));
    end
    cmp("t2_count", 64'(bus.count), 64'd3);
    cmp("t2_full", 64'(bus.full), 64'd0);

    // 3: fill to DEPTH, then overflow
    do_reset();
    for (int i = 0; i < 5; i++) press(16'(16'h1100 + i), 1'b0);
    cmp("t3_nwrites", 64'(wlog_addr.size()), 64'd4);
    for (int i = 0; i < wlog_addr.size() && i < 4; i++) cmp("t3_addr", 64'(wlog_addr[i]), 64'(i));
    cmp("t3_full", 64'(bus.full), 64'd1);
    cmp("t3_overflow", 64'(bus.overflow), 64'd1);
    cmp("t3_count", 64'(bus.count), 64'd4);

    // 4: simultaneous enter+finish, ignored enter in DONE, restart
    do_reset();
    press(16'h0A0B, 1'b0);
    press(16'h0C0D, 1'b1);
    cmp("t4_nwrites", 64'(wlog_addr.size()), 64'd2);
    if (wlog_addr.size() > 1) cmp("t4_addr", 64'(wlog_addr[1]), 64'd1);
    cmp("t4_done", 64'(bus.done), 64'd1);
    press(16'h0E0F, 1'b0);
    cmp("t4_ignored", 64'(wlog_addr.size()), 64'd2);
    bus.restart = 1'b1; tick(); bus.restart = 1'b0; tick();
    cmp("t4_rs_done", 64'(bus.done), 64'd0);
    cmp("t4_rs_count", 64'(bus.count), 64'd0);
    cmp("t4_rs_ovf", 64'(bus.overflow), 64'd0);
    press(16'h1234, 1'b0);
    cmp("t4_nwrites2", 64'(wlog_addr.size()), 64'd3);
    if (wlog_addr.size() > 2) cmp("t4_addr2", 64'(wlog_addr[2]), 64'd0);

    // 5: reset landing on the WRITE cycle suppresses the write
    do_reset();
    bus.coord_in = 16'hBEEF; bus.enter_req = 1'b1;
    for (int i = 0; i < 40 && !m_wr; i++) tick();
    cmp("t5_in_write", 64'(bus.mem_wren), 64'h3);
    reset = 1'b1; bus.enter_req = 1'b0;
    #1;
    cmp("t5_wren_forced", 64'(bus.mem_wren), 64'd0);
    tick();
    reset = 1'b0;
    repeat (6) tick();
    cmp("t5_nwrites", 64'(wlog_addr.size()), 64'd0);
    cmp("t5_count", 64'(bus.count), 64'd0);
    cmp("t5_done", 64'(bus.done), 64'd0);

`ifdef COORD_DEBOUNCE_EN
    // short glitch is filtered
    do_reset();
    bus.enter_req = 1'b1; repeat (10) tick();
    bus.enter_req = 1'b0; repeat (30) tick();
    cmp("db_glitch", 64'(wlog_addr.size()), 64'd0);
`endif

    // randomized traffic against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      bus.coord_in = DW'($urandom);
      if ($urandom_range(0, 7) == 0) bus.enter_req = ~bus.enter_req;
      if ($urandom_range(0, 39) == 0) bus.finish_req = ~bus.finish_req;
      bus.restart = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
